// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle sequencer and the RV32I datapath.
// The sequencer takes the master side; the datapath (or a bench) takes the slave side.
interface multicycle_controller_if #(
    parameter int RETIRE_COUNT_WIDTH = 32
);
    logic [6:0]                    opcode;
    logic                          branch_taken;
    logic                          ir_write;
    logic                          pc_write;
    logic                          select_pc_value;
    logic                          write_enable_register;
    logic                          write_enable_memory;
    logic                          select_alu_op1;
    logic                          select_alu_op2;
    logic                          alu_force_add;
    logic [1:0]                    select_rdv;
    logic                          select_address_source;
    logic                          illegal_instr;
    logic [2:0]                    state;
    logic [RETIRE_COUNT_WIDTH-1:0] retire_count;

    modport master (
        input  opcode, branch_taken,
        output ir_write, pc_write, select_pc_value, write_enable_register,
               write_enable_memory, select_alu_op1, select_alu_op2, alu_force_add,
               select_rdv, select_address_source, illegal_instr, state, retire_count
    );

    modport slave (
        output opcode, branch_taken,
        input  ir_write, pc_write, select_pc_value, write_enable_register,
               write_enable_memory, select_alu_op1, select_alu_op2, alu_force_add,
               select_rdv, select_address_source, illegal_instr, state, retire_count
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK, all controls registered.
// Latency L+3 (ALU/jump/branch), 2L+3 (load), L+4 (store); no backpressure, TRAP holds until reset.
module multicycle_controller #(
    parameter int MEM_READ_LATENCY   = 1,
    parameter int RETIRE_COUNT_WIDTH = 32
) (
    input logic                     clk,
    input logic                     reset,
    multicycle_controller_if.master bus
);
    localparam int CW = (MEM_READ_LATENCY > 1) ? $clog2(MEM_READ_LATENCY) : 1;
    localparam logic [CW-1:0] LAST = CW'(MEM_READ_LATENCY - 1);

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd7
    } state_t;

    typedef enum logic [3:0] {
        C_R, C_I, C_LD, C_ST, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BR
    } cls_t;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       select_pc_value;
        logic       write_enable_register;
        logic       write_enable_memory;
        logic       select_alu_op1;
        logic       select_alu_op2;
        logic       alu_force_add;
        logic [1:0] select_rdv;
        logic       select_address_source;
        logic       illegal_instr;
    } ctl_t;

    state_t                        state_q, state_d;
    cls_t                          cls_q, cls_d, dec_cls;
    logic                          dec_ok;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic                          taken_q, taken_d;
    logic                          run_q;
    logic [RETIRE_COUNT_WIDTH-1:0] retire_q;
    ctl_t                          ctl_q;

    always_comb begin
        dec_cls = C_R;
        dec_ok  = 1'b1;
        case (bus.opcode)
            7'b0110011: dec_cls = C_R;
            7'b0010011: dec_cls = C_I;
            7'b0000011: dec_cls = C_LD;
            7'b0100011: dec_cls = C_ST;
            7'b0110111: dec_cls = C_LUI;
            7'b0010111: dec_cls = C_AUIPC;
            7'b1101111: dec_cls = C_JAL;
            7'b1100111: dec_cls = C_JALR;
            7'b1100011: dec_cls = C_BR;
            default:    dec_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cls_d   = cls_q;
        taken_d = taken_q;
        // First edge after reset release (re)enters FETCH so its outputs get loaded.
        if (!run_q) begin
            state_d = FETCH;
            cnt_d   = '0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (cnt_q == LAST) begin
                        state_d = DECODE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DECODE: begin
                    if (dec_ok) begin
                        state_d = EXECUTE;
                        cls_d   = dec_cls;
                    end else begin
                        state_d = TRAP;
                    end
                end
                EXECUTE: begin
                    if (cls_q == C_BR) taken_d = bus.branch_taken;
                    state_d = (cls_q == C_LD || cls_q == C_ST) ? MEM : WRITEBACK;
                end
                MEM: begin
                    if (cls_q == C_ST || cnt_q == LAST) begin
                        state_d = WRITEBACK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                WRITEBACK: begin
                    state_d = FETCH;
                    cnt_d   = '0;
                end
                TRAP:    state_d = TRAP;
                default: state_d = TRAP;
            endcase
        end
    end

    // Controls for the cycle spent in state s, so they can be registered alongside the state.
    function automatic ctl_t ctl_for(state_t s, cls_t c, logic [CW-1:0] n, logic tk);
        ctl_t o;
        o = '0;
        if (s == EXECUTE || s == MEM || s == WRITEBACK) begin
            case (c)
                C_R:     begin o.select_alu_op1 = 1'b1; o.select_alu_op2 = 1'b1; o.select_rdv = 2'b01; end
                C_I:     begin o.select_alu_op1 = 1'b1; o.select_rdv = 2'b01; end
                C_LD:    begin o.select_alu_op1 = 1'b1; o.select_rdv = 2'b11; end
                C_ST:    o.select_alu_op1 = 1'b1;
                C_LUI:   begin o.select_alu_op1 = 1'b1; o.select_rdv = 2'b10; end
                C_AUIPC: o.select_rdv = 2'b01;
                C_JAL:   o.select_rdv = 2'b00;
                C_JALR:  o.select_alu_op1 = 1'b1;
                C_BR:    begin o.select_alu_op1 = 1'b1; o.select_alu_op2 = 1'b1; end
                default: o.select_rdv = 2'b00;
            endcase
        end
        case (s)
            FETCH: o.ir_write = (n == LAST);
            MEM: begin
                o.select_address_source = 1'b1;
                o.write_enable_memory   = (c == C_ST);
            end
            WRITEBACK: begin
                o.pc_write              = 1'b1;
                o.write_enable_register = !(c == C_ST || c == C_BR);
                o.select_pc_value       = (c == C_JAL) || (c == C_JALR) || (c == C_BR && tk);
                // Branch target is PC + imm, computed by the ALU in this cycle.
                if (c == C_BR) begin
                    o.select_alu_op1 = 1'b0;
                    o.select_alu_op2 = 1'b0;
                    o.alu_force_add  = 1'b1;
                end
            end
            TRAP:    o.illegal_instr = 1'b1;
            default: o.illegal_instr = 1'b0;
        endcase
        return o;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FETCH;
            cnt_q    <= '0;
            cls_q    <= C_R;
            taken_q  <= 1'b0;
            run_q    <= 1'b0;
            retire_q <= '0;
            ctl_q    <= '0;
        end else begin
            run_q   <= 1'b1;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cls_q   <= cls_d;
            taken_q <= taken_d;
            ctl_q   <= ctl_for(state_d, cls_d, cnt_d, taken_d);
            if (run_q && state_q == WRITEBACK) retire_q <= retire_q + 1'b1;
        end
    end

    assign bus.ir_write              = ctl_q.ir_write;
    assign bus.pc_write              = ctl_q.pc_write;
    assign bus.select_pc_value       = ctl_q.select_pc_value;
    assign bus.write_enable_register = ctl_q.write_enable_register;
    assign bus.write_enable_memory   = ctl_q.write_enable_memory;
    assign bus.select_alu_op1        = ctl_q.select_alu_op1;
    assign bus.select_alu_op2        = ctl_q.select_alu_op2;
    assign bus.alu_force_add         = ctl_q.alu_force_add;
    assign bus.select_rdv            = ctl_q.select_rdv;
    assign bus.select_address_source = ctl_q.select_address_source;
    assign bus.illegal_instr         = ctl_q.illegal_instr;
    assign bus.state                 = state_q;
    assign bus.retire_count          = retire_q;
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: one DUT with single-cycle memory reads, one with two-cycle reads.
// Outputs are sampled on the falling edge; cycle 0 is the first cycle after the post-reset edge.
module tb_multicycle_controller;
    logic clk;
    logic reset;
    int   tests;
    int   fails;

    multicycle_controller_if #(.RETIRE_COUNT_WIDTH(32)) if1 ();
    multicycle_controller_if #(.RETIRE_COUNT_WIDTH(32)) if2 ();

    multicycle_controller #(.MEM_READ_LATENCY(1), .RETIRE_COUNT_WIDTH(32)) dut1 (
        .clk(clk), .reset(reset), .bus(if1.master));
    multicycle_controller #(.MEM_READ_LATENCY(2), .RETIRE_COUNT_WIDTH(32)) dut2 (
        .clk(clk), .reset(reset), .bus(if2.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {ir_write, pc_write, write_enable_register, write_enable_memory}
    logic [3:0]  en1, en2;
    logic [11:0] all1, all2;
    assign en1  = {if1.ir_write, if1.pc_write, if1.write_enable_register, if1.write_enable_memory};
    assign en2  = {if2.ir_write, if2.pc_write, if2.write_enable_register, if2.write_enable_memory};
    assign all1 = {en1, if1.select_pc_value, if1.select_alu_op1, if1.select_alu_op2,
                   if1.alu_force_add, if1.select_rdv, if1.select_address_source, if1.illegal_instr};
    assign all2 = {en2, if2.select_pc_value, if2.select_alu_op1, if2.select_alu_op2,
                   if2.alu_force_add, if2.select_rdv, if2.select_address_source, if2.illegal_instr};

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if ({all1, all2} !== 24'h0) begin
            fails++; $display("FAIL reset_outputs: got %h expected 000000", {all1, all2});
        end
        tests++;
        if ({if1.state, if2.state} !== 6'd0 || if1.retire_count !== 32'd0) begin
            fails++; $display("FAIL reset_state: got %0d/%0d rc %0d expected 0/0 rc 0",
                              if1.state, if2.state, if1.retire_count);
        end
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (en1 !== 4'b1000 || en2 !== 4'b0000) begin
            fails++; $display("FAIL reset_first_fetch: got %b/%b expected 1000/0000", en1, en2);
        end
    endtask

    task automatic test_r_type();
        logic [2:0] es [0:4];
        logic [3:0] ee [0:4];
        es = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        ee = '{4'b1000, 4'b0000, 4'b0000, 4'b0110, 4'b1000};
        if1.opcode = 7'b0110011;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (if1.state !== es[i] || en1 !== ee[i]) begin
                fails++; $display("FAIL r_type c%0d: got state %0d en %b expected state %0d en %b",
                                  i, if1.state, en1, es[i], ee[i]);
            end
            if (i == 2 || i == 3) begin
                tests++;
                if ({if1.select_alu_op1, if1.select_alu_op2, if1.select_rdv} !== 4'b1101) begin
                    fails++; $display("FAIL r_type_sel c%0d: got %b%b%b expected 1101", i,
                                      if1.select_alu_op1, if1.select_alu_op2, if1.select_rdv);
                end
            end
            if (i == 4) begin
                tests++;
                if (if1.retire_count !== 32'd1) begin
                    fails++; $display("FAIL r_type_retire: got %0d expected 1", if1.retire_count);
                end
            end
        end
    endtask

    task automatic test_load_l2();
        logic [2:0] es [0:7];
        logic [3:0] ee [0:7];
        logic       ea [0:7];
        es = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd4, 3'd0};
        ee = '{4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b0000};
        ea = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        if2.opcode = 7'b0000011;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests++;
            if (if2.state !== es[i] || en2 !== ee[i] || if2.select_address_source !== ea[i]) begin
                fails++; $display("FAIL load_l2 c%0d: got state %0d en %b addr %b expected %0d %b %b",
                                  i, if2.state, en2, if2.select_address_source, es[i], ee[i], ea[i]);
            end
            if (i == 6) begin
                tests++;
                if (if2.select_rdv !== 2'b11) begin
                    fails++; $display("FAIL load_l2_rdv: got %b expected 11", if2.select_rdv);
                end
            end
        end
        tests++;
        if (if2.retire_count !== 32'd1) begin
            fails++; $display("FAIL load_l2_retire: got %0d expected 1", if2.retire_count);
        end
    endtask

    task automatic test_store();
        logic [2:0] es [0:5];
        logic [3:0] ee [0:5];
        es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        ee = '{4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0100, 4'b1000};
        if1.opcode = 7'b0100011;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests++;
            if (if1.state !== es[i] || en1 !== ee[i]) begin
                fails++; $display("FAIL store c%0d: got state %0d en %b expected state %0d en %b",
                                  i, if1.state, en1, es[i], ee[i]);
            end
        end
    endtask

    task automatic test_branch(input logic tk);
        if1.opcode       = 7'b1100011;
        if1.branch_taken = !tk;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (if1.state !== 3'd2 || {if1.select_alu_op1, if1.select_alu_op2, if1.alu_force_add} !== 3'b110) begin
            fails++; $display("FAIL branch_exec tk=%b: got state %0d sel %b%b%b expected 2 110", tk,
                              if1.state, if1.select_alu_op1, if1.select_alu_op2, if1.alu_force_add);
        end
        if1.branch_taken = tk;
        @(negedge clk);
        if1.branch_taken = !tk;
        tests++;
        if (if1.state !== 3'd4 || en1 !== 4'b0100 ||
            {if1.select_alu_op1, if1.select_alu_op2, if1.alu_force_add, if1.select_pc_value} !== {3'b001, tk}) begin
            fails++; $display("FAIL branch_wb tk=%b: got state %0d en %b sel %b%b%b pc %b expected 4 0100 001 %b",
                              tk, if1.state, en1, if1.select_alu_op1, if1.select_alu_op2,
                              if1.alu_force_add, if1.select_pc_value, tk);
        end
    endtask

    task automatic test_trap();
        int bad;
        bad = 0;
        if1.opcode = 7'b0000000;
        do_reset();
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (if1.state !== 3'd7 || if1.illegal_instr !== 1'b1) begin
            fails++; $display("FAIL trap_entry: got state %0d illegal %b expected 7 1",
                              if1.state, if1.illegal_instr);
        end
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (if1.state !== 3'd7 || en1 !== 4'b0000 || if1.illegal_instr !== 1'b1 ||
                if1.retire_count !== 32'd0) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++; $display("FAIL trap_hold: got %0d bad cycles expected 0", bad);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (if1.state !== 3'd0 || if1.illegal_instr !== 1'b0) begin
            fails++; $display("FAIL trap_reset: got state %0d illegal %b expected 0 0",
                              if1.state, if1.illegal_instr);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        if2.opcode = 7'b0000011;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 7) begin
                tests++;
                if (if2.retire_count !== 32'd1 || if2.state !== 3'd0) begin
                    fails++; $display("FAIL mid_load_first: got rc %0d state %0d expected 1 0",
                                      if2.retire_count, if2.state);
                end
            end
        end
        tests++;
        if (if2.state !== 3'd3 || if2.select_address_source !== 1'b1) begin
            fails++; $display("FAIL mid_load_mem: got state %0d addr %b expected 3 1",
                              if2.state, if2.select_address_source);
        end
        reset = 1'b1;
        #1;
        tests++;
        if (all2 !== 12'h0 || if2.state !== 3'd0 || if2.retire_count !== 32'd0) begin
            fails++; $display("FAIL mid_load_async: got out %h state %0d rc %0d expected 000 0 0",
                              all2, if2.state, if2.retire_count);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (if2.state !== 3'd0 || en2 !== 4'b1000) begin
            fails++; $display("FAIL mid_load_refetch: got state %0d en %b expected 0 1000",
                              if2.state, en2);
        end
        @(negedge clk);
        tests++;
        if (if2.state !== 3'd1) begin
            fails++; $display("FAIL mid_load_decode: got state %0d expected 1", if2.state);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        if1.opcode = 7'b0110011;
        if2.opcode = 7'b0110011;
        if1.branch_taken = 1'b0;
        if2.branch_taken = 1'b0;
        test_reset();
        test_r_type();
        test_load_l2();
        test_store();
        test_branch(1'b1);
        test_branch(1'b0);
        test_trap();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
